// File: rtl/integer_array_loader.sv
// Assembles a raster-ordered stream of 8-bit pixels into an N x N window (N = num_pixel+7)
// and holds it until the consumer acknowledges it.
module integer_array_loader #(
    parameter int num_pixel = 8
) (
    input  logic                                               clock,
    input  logic                                               reset,
    input  logic [7:0]                                         pix_in,
    input  logic                                               pix_valid,
    input  logic                                               pix_sof,
    output logic                                               pix_ready,
    output logic [(num_pixel+7)*(num_pixel+7)*8-1:0]           integer_array,
    output logic                                               array_valid,
    input  logic                                               array_ack,
    output logic [7:0]                                         pix_count,
    output logic                                               sof_err,
    output logic [1:0]                                         fsm_state
);

    localparam int N = num_pixel + 7;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2
    } state_t;

    // Handshake: a pixel transfers on a rising edge where pix_valid and pix_ready are both 1;
    // pix_ready is 1 whenever the FSM is in IDLE or LOAD, so pix_in/pix_sof need no holding.

    state_t      state;
    logic [3:0]  row_cnt;
    logic [3:0]  col_cnt;
    logic [10:0] byte_idx;

    assign byte_idx  = 11'(row_cnt) * 11'(N) + 11'(col_cnt);
    assign fsm_state = state;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            integer_array <= '0;
            array_valid   <= 1'b0;
            pix_ready     <= 1'b1;
            pix_count     <= 8'd0;
            row_cnt       <= 4'd0;
            col_cnt       <= 4'd0;
            sof_err       <= 1'b0;
        end else begin
            sof_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pix_valid) begin
                        if (pix_sof) begin
                            integer_array[7:0] <= pix_in;
                            row_cnt            <= 4'd0;
                            col_cnt            <= 4'd1;
                            pix_count          <= 8'd1;
                            state              <= LOAD;
                        end else begin
                            sof_err <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (pix_valid) begin
                        if (pix_sof) begin
                            // Restart: only (0,0) is rewritten, older bytes linger until reached.
                            integer_array[7:0] <= pix_in;
                            row_cnt            <= 4'd0;
                            col_cnt            <= 4'd1;
                            pix_count          <= 8'd1;
                            sof_err            <= 1'b1;
                        end else begin
                            integer_array[{byte_idx, 3'b000} +: 8] <= pix_in;
                            pix_count <= pix_count + 8'd1;
                            if (col_cnt == 4'(N - 1)) begin
                                col_cnt <= 4'd0;
                                if (row_cnt == 4'(N - 1)) begin
                                    row_cnt     <= 4'd0;
                                    state       <= FULL;
                                    array_valid <= 1'b1;
                                    pix_ready   <= 1'b0;
                                end else begin
                                    row_cnt <= row_cnt + 4'd1;
                                end
                            end else begin
                                col_cnt <= col_cnt + 4'd1;
                            end
                        end
                    end
                end
                FULL: begin
                    if (array_ack) begin
                        state       <= IDLE;
                        array_valid <= 1'b0;
                        pix_ready   <= 1'b1;
                        pix_count   <= 8'd0;
                        row_cnt     <= 4'd0;
                        col_cnt     <= 4'd0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    pix_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_integer_array_loader.sv
// Directed bench for integer_array_loader: full loads, stalls, FULL hold, sof restarts and resets.
module tb_integer_array_loader;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [7:0]    pix_in = 8'd0;
    logic          pix_valid = 1'b0;
    logic          pix_sof = 1'b0;
    logic          pix_ready;
    logic [1799:0] integer_array;
    logic          array_valid;
    logic          array_ack = 1'b0;
    logic [7:0]    pix_count;
    logic          sof_err;
    logic [1:0]    fsm_state;

    int n_checks = 0;
    int n_pass   = 0;
    int cycles;

    integer_array_loader dut (
        .clock         (clock),
        .reset         (reset),
        .pix_in        (pix_in),
        .pix_valid     (pix_valid),
        .pix_sof       (pix_sof),
        .pix_ready     (pix_ready),
        .integer_array (integer_array),
        .array_valid   (array_valid),
        .array_ack     (array_ack),
        .pix_count     (pix_count),
        .sof_err       (sof_err),
        .fsm_state     (fsm_state)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Row r of the pattern byte(r,c) = (r*15 + c + off) mod 256.
    function automatic logic [119:0] pat_row(input int r, input int off);
        logic [119:0] v;
        v = '0;
        for (int c = 0; c < 15; c++) v[c*8 +: 8] = 8'((r*15 + c + off) % 256);
        return v;
    endfunction

    task automatic check_pattern(input string tag, input int off);
        for (int r = 0; r < 15; r++)
            check($sformatf("%s_row%0d", tag, r), 128'(integer_array[r*120 +: 120]), 128'(pat_row(r, off)));
    endtask

    task automatic check_zero(input string tag);
        for (int r = 0; r < 15; r++)
            check($sformatf("%s_row%0d", tag, r), 128'(integer_array[r*120 +: 120]), 128'd0);
    endtask

    task automatic send_pix(input logic [7:0] v, input logic sof);
        pix_valid = 1'b1;
        pix_in    = v;
        pix_sof   = sof;
        step();
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
    endtask

    // Loads the (r*15+c) pattern; gap inserts one idle cycle between pixels.
    task automatic load_window(input logic gap, output int ncyc);
        ncyc = 0;
        for (int i = 0; i < 225; i++) begin
            if (i == 224) check("valid_before_last", 128'(array_valid), 128'd0);
            send_pix(8'(i % 256), i == 0);
            ncyc++;
            if (i == 0) check("count_first", 128'(pix_count), 128'd1);
            if (gap && i != 224) begin
                step();
                ncyc++;
            end
        end
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check({tag, "_valid"}, 128'(array_valid), 128'd0);
        check({tag, "_ready"}, 128'(pix_ready), 128'd1);
        check({tag, "_count"}, 128'(pix_count), 128'd0);
        check({tag, "_soferr"}, 128'(sof_err), 128'd0);
        check_zero({tag, "_arr"});
    endtask

    initial begin
        step();
        do_reset("rst0");

        // Pixel without sof in IDLE is dropped and flagged.
        send_pix(8'h55, 1'b0);
        check("idle_nosof_err", 128'(sof_err), 128'd1);
        check("idle_nosof_count", 128'(pix_count), 128'd0);
        check("idle_nosof_row0", 128'(integer_array[119:0]), 128'd0);
        step();
        check("idle_nosof_err_clear", 128'(sof_err), 128'd0);

        // Back-to-back full window.
        load_window(1'b0, cycles);
        check("b2b_cycles", 128'(cycles), 128'd225);
        check("b2b_valid", 128'(array_valid), 128'd1);
        check("b2b_ready", 128'(pix_ready), 128'd0);
        check("b2b_count", 128'(pix_count), 128'd225);
        check_pattern("b2b", 0);

        // FULL ignores pixels and sof; contents stay put until ack.
        for (int k = 0; k < 10; k++) begin
            pix_valid = 1'b1;
            pix_in    = 8'($urandom_range(0, 255));
            pix_sof   = k[0];
            step();
            check("full_ready", 128'(pix_ready), 128'd0);
            check("full_valid", 128'(array_valid), 128'd1);
            check("full_soferr", 128'(sof_err), 128'd0);
            check("full_count", 128'(pix_count), 128'd225);
            check_pattern("full_hold", 0);
        end
        pix_valid = 1'b0;
        pix_sof   = 1'b0;
        array_ack = 1'b1;
        step();
        array_ack = 1'b0;
        check("ack_valid", 128'(array_valid), 128'd0);
        check("ack_ready", 128'(pix_ready), 128'd1);
        check("ack_count", 128'(pix_count), 128'd0);
        check_pattern("ack_retain", 0);

        // array_ack in IDLE is ignored.
        array_ack = 1'b1;
        step();
        array_ack = 1'b0;
        check("idle_ack_ready", 128'(pix_ready), 128'd1);

        // 40 pixels of an offset pattern, then a restart with 0xAA.
        for (int i = 0; i < 40; i++) send_pix(8'((i + 100) % 256), i == 0);
        check("p40_count", 128'(pix_count), 128'd40);
        send_pix(8'hAA, 1'b1);
        check("restart_err", 128'(sof_err), 128'd1);
        check("restart_count", 128'(pix_count), 128'd1);
        check("restart_b00", 128'(integer_array[7:0]), 128'hAA);
        check("restart_b01", 128'(integer_array[8 +: 8]), 128'd101);
        check("restart_b29", 128'(integer_array[(2*15+9)*8 +: 8]), 128'h8B);
        check("restart_b2a", 128'(integer_array[(2*15+10)*8 +: 8]), 128'(40));
        step();
        check("restart_err_clear", 128'(sof_err), 128'd0);
        check("stall_count", 128'(pix_count), 128'd1);
        check("stall_ready", 128'(pix_ready), 128'd1);

        // Rewrite (0,1)..(2,9) then confirm (2,9) took the new value.
        for (int i = 1; i < 40; i++) send_pix(8'hC0 + 8'(i % 16), 1'b0);
        check("rewrite_b29", 128'(integer_array[(2*15+9)*8 +: 8]), 128'(8'hC0 + 8'(39 % 16)));
        for (int i = 40; i < 100; i++) send_pix(8'(i), 1'b0);
        check("p100_count", 128'(pix_count), 128'd100);
        check("p100_valid", 128'(array_valid), 128'd0);

        do_reset("rst_mid");
        load_window(1'b0, cycles);
        check("fresh_valid", 128'(array_valid), 128'd1);
        check("fresh_count", 128'(pix_count), 128'd225);
        check_pattern("fresh", 0);

        array_ack = 1'b1;
        step();
        array_ack = 1'b0;

        // Toggling pix_valid: last handshake on the 449th edge.
        load_window(1'b1, cycles);
        check("tog_cycles", 128'(cycles), 128'd449);
        check("tog_valid", 128'(array_valid), 128'd1);
        check("tog_count", 128'(pix_count), 128'd225);
        check_pattern("tog", 0);

        // Reset wins while FULL.
        array_ack = 1'b1;
        do_reset("rst_full");
        array_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/integer_array_loader.md
INTEGER_ARRAY_LOADER -- requirements
Module: integer_array_loader

Interface
REQ-001 SHALL have parameter num_pixel, default 8, giving interpolated block width; window edge N = num_pixel+7 (15 at default); only the default needs support.
REQ-002 SHALL have port clock  input  1  the single clock; all logic is on its rising edge.
REQ-003 SHALL have port reset  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port pix_in  input  8  integer pixel sample, raster order (row-major, column 0 first).
REQ-005 SHALL have port pix_valid  input  1  pix_in is valid this cycle.
REQ-006 SHALL have port pix_sof  input  1  qualifies pix_in as pixel (0,0) of a new window; meaningful only with pix_valid.
REQ-007 SHALL have port pix_ready  output  1  loader accepts a pixel this cycle.
REQ-008 SHALL have port integer_array  output  1800  assembled window; row r at bits [r*120 +: 120], column c of row r at [r*120 + c*8 +: 8].
REQ-009 SHALL have port array_valid  output  1  integer_array holds a complete window.
REQ-010 SHALL have port array_ack  input  1  consumer has finished reading the window.
REQ-011 SHALL have port pix_count  output  8  pixels written into the current window (0..225).
REQ-012 SHALL have port sof_err  output  1  one-cycle pulse on a protocol violation.

Function
REQ-013 A pixel SHALL be accepted only in a cycle where pix_valid and pix_ready are both 1.
REQ-014 SHALL implement states IDLE, LOAD, FULL; pix_ready = 1 in IDLE and LOAD, 0 in FULL.
REQ-015 IDLE: accepted pixel with pix_sof=1 written to (0,0), column counter -> 1, row counter -> 0, pix_count -> 1, state -> LOAD.
REQ-016 IDLE: accepted pixel with pix_sof=0 discarded, array unchanged, sof_err pulses next cycle.
REQ-017 LOAD: accepted pixel with pix_sof=0 written to (row, col); column increments and wraps 14 -> 0 with row increment; pix_count increments.
REQ-018 LOAD: accepted pixel with pix_sof=1 restarts the window: written to (0,0), counters as REQ-015, sof_err pulses next cycle; stale bytes elsewhere remain until overwritten.
REQ-019 Acceptance of pixel (14,14) SHALL move LOAD -> FULL; array_valid = 1 from the next cycle; pix_count = 225.
REQ-020 FULL: integer_array bit-stable; pix_valid/pix_sof ignored; sof_err never pulses.
REQ-021 FULL with array_ack = 1 SHALL return to IDLE next cycle: array_valid = 0, pix_count = 0, counters 0; integer_array contents retained.
REQ-022 array_ack outside FULL SHALL be ignored.
REQ-023 Cycles with pix_valid = 0 SHALL leave all state unchanged (stall anywhere in LOAD permitted).
REQ-024 Only the addressed byte SHALL change on a write; all other bytes of integer_array hold.
REQ-025 Throughput: one pixel per cycle in LOAD; minimum window period 225 load cycles + 1 FULL cycle (ack in first FULL cycle).
REQ-026 Row/column counters SHALL be 4-bit, never exceeding 14.

Reset
REQ-027 reset = 1 at a clock edge SHALL force state IDLE, integer_array = 0, array_valid = 0, pix_count = 0, counters = 0, sof_err = 0, pix_ready = 1 next cycle.
REQ-028 reset SHALL take priority over every other input, including mid-LOAD and in FULL; the partial window is discarded.

Verification
REQ-029 Reset, then 225 back-to-back pixels value (r*15+c) mod 256 with sof on first -> array_valid 1 cycle after last handshake; byte (r,c) = (r*15+c) mod 256; pix_count = 225.
REQ-030 In FULL, drive pix_valid = 1 for 10 cycles, then array_ack = 1 -> pix_ready = 0 and array stable throughout; next cycle array_valid = 0, pix_ready = 1, pix_count = 0.
REQ-031 Stream with pix_valid toggling 1/0 every cycle -> same array as REQ-029, completion after 449 cycles.
REQ-032 After 40 pixels, pix_sof = 1 with value 0xAA -> sof_err pulses once; pix_count = 1; byte (0,0) = 0xAA; byte (2,9) keeps its earlier value until rewritten.
REQ-033 In IDLE, pixel without sof -> sof_err pulses, pix_count stays 0, array unchanged.
REQ-034 reset asserted after 100 pixels -> next cycle all outputs per REQ-027; fresh 225-pixel load completes normally.
